exc_ctrl: RTL and testbench

Exception and interrupt sequencer between the write-back stage and the CSR file. Each cycle it picks the highest-priority event for the instruction in WB: a pending interrupt, a synchronous exception, or an `ertn`. It then pulses the CSR update strobes (`wb_ex` / `eret_flush`) and runs the pipeline flush. Finally it hands the fetch stage a redirect PC through a valid/ready handshake.

---
 rtl/exc_ctrl.sv | 159 +++++++++++++++
 tb/tb_exc_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception / interrupt sequencer between write-back and the CSR file.
//
// Picks the highest-priority event for the WB instruction (interrupt, synchronous
// exception, ertn). It pulses the CSR strobes for one cycle, holds the pipeline
// flush for FLUSH_CYCLES cycles, and then offers a redirect PC to fetch through a
// valid/ready handshake.
//
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   wb_valid, wb_pc, wb_exc,  WB instruction status: exception flags
//   wb_vaddr, wb_ertn           [0] ADEF [1] INE [2] SYS [3] BRK [4] ALE [5] ADEM
//   csr_*                     CSR state: interrupt enables/status, entry/return PCs
//   wb_ex, wb_ecode,          exception strobe and cause to the CSR file
//   wb_esubcode, wb_badv_we,
//   wb_badv
//   eret_flush                ertn strobe to the CSR file
//   wb_kill                   suppresses commit of the WB instruction
//   pipe_flush                flushes IF..MEM
//   redirect_valid/_pc/_ready redirect handshake towards fetch

module exc_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [5:0]  wb_exc,
  input  logic [31:0] wb_vaddr,
  input  logic        wb_ertn,
  input  logic        csr_crmd_ie,
  input  logic [12:0] csr_ecfg_lie,
  input  logic [12:0] csr_estat_is,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic        wb_badv_we,
  output logic [31:0] wb_badv,
  output logic        eret_flush,
  output logic        wb_kill,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {StIdle, StFlush, StRedirect} state_e;

  state_e            state_q, state_d;
  logic              int_pend_q, int_pend_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       target_q, target_d;

  logic        idle;
  logic        exc_sel;
  logic        take;
  logic [5:0]  sel_ecode;
  logic [8:0]  sel_esubcode;
  logic        sel_badv_we;
  logic [31:0] sel_badv;

  assign idle    = (state_q == StIdle);
  // Interrupts and synchronous exceptions both override ertn.
  assign exc_sel = int_pend_q | (|wb_exc);
  assign take    = idle & wb_valid & (exc_sel | wb_ertn);

  // Cause decode, highest priority first.
  always_comb begin
    sel_ecode    = 6'h00;
    sel_esubcode = 9'd0;
    sel_badv_we  = 1'b0;
    sel_badv     = 32'd0;
    if (int_pend_q) begin
      sel_ecode = 6'h00;
    end else if (wb_exc[0]) begin
      sel_ecode   = 6'h08;
      sel_badv_we = 1'b1;
      sel_badv    = wb_pc;
    end else if (wb_exc[1]) begin
      sel_ecode = 6'h0d;
    end else if (wb_exc[2]) begin
      sel_ecode = 6'h0b;
    end else if (wb_exc[3]) begin
      sel_ecode = 6'h0c;
    end else if (wb_exc[4]) begin
      sel_ecode   = 6'h09;
      sel_badv_we = 1'b1;
      sel_badv    = wb_vaddr;
    end else if (wb_exc[5]) begin
      sel_ecode    = 6'h08;
      sel_esubcode = 9'd1;
      sel_badv_we  = 1'b1;
      sel_badv     = wb_vaddr;
    end
  end

  // Strobes exist only in the take cycle; data outputs are zero otherwise.
  always_comb begin
    wb_ex       = take & exc_sel;
    eret_flush  = take & ~exc_sel;
    wb_ecode    = wb_ex ? sel_ecode : 6'h00;
    wb_esubcode = wb_ex ? sel_esubcode : 9'd0;
    wb_badv_we  = wb_ex & sel_badv_we;
    wb_badv     = wb_badv_we ? sel_badv : 32'd0;
    wb_kill     = idle ? wb_ex : wb_valid;
    pipe_flush  = take | ~idle;
  end

  assign redirect_valid = (state_q == StRedirect);
  assign redirect_pc    = target_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    int_pend_d = csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
    unique case (state_q)
      StIdle: begin
        if (take) begin
          state_d  = StFlush;
          cnt_d    = CntW'(FLUSH_CYCLES - 1);
          target_d = exc_sel ? csr_eentry : csr_era;
        end
      end
      StFlush: begin
        if (cnt_q == '0) begin
          state_d = StRedirect;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRedirect: begin
        if (redirect_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      int_pend_q <= 1'b0;
      cnt_q      <= '0;
      target_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      int_pend_q <= int_pend_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl (FLUSH_CYCLES = 2).
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns later.

module tb_exc_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [5:0]  wb_exc;
  logic [31:0] wb_vaddr;
  logic        wb_ertn;
  logic        csr_crmd_ie;
  logic [12:0] csr_ecfg_lie;
  logic [12:0] csr_estat_is;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        wb_badv_we;
  logic [31:0] wb_badv;
  logic        eret_flush;
  logic        wb_kill;
  logic        pipe_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  int errors = 0;
  int checks = 0;

  exc_ctrl #(
    .FLUSH_CYCLES(2)
  ) u_dut (
    .clock         (clock),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .wb_pc         (wb_pc),
    .wb_exc        (wb_exc),
    .wb_vaddr      (wb_vaddr),
    .wb_ertn       (wb_ertn),
    .csr_crmd_ie   (csr_crmd_ie),
    .csr_ecfg_lie  (csr_ecfg_lie),
    .csr_estat_is  (csr_estat_is),
    .csr_eentry    (csr_eentry),
    .csr_era       (csr_era),
    .wb_ex         (wb_ex),
    .wb_ecode      (wb_ecode),
    .wb_esubcode   (wb_esubcode),
    .wb_badv_we    (wb_badv_we),
    .wb_badv       (wb_badv),
    .eret_flush    (eret_flush),
    .wb_kill       (wb_kill),
    .pipe_flush    (pipe_flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .redirect_ready(redirect_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic wb_idle();
    wb_valid = 1'b0;
    wb_exc   = 6'b0;
    wb_ertn  = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    wb_valid       = 1'b0;
    wb_pc          = 32'h1c00_0100;
    wb_exc         = 6'b0;
    wb_vaddr       = 32'h0000_0003;
    wb_ertn        = 1'b0;
    csr_crmd_ie    = 1'b0;
    csr_ecfg_lie   = 13'd0;
    csr_estat_is   = 13'd0;
    csr_eentry     = 32'h1c00_8000;
    csr_era        = 32'h1c00_0200;
    redirect_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
    check("rst_pipe_flush", 32'(pipe_flush), 32'd0);
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_wb_kill", 32'(wb_kill), 32'd0);

    // ALE
    tick();
    wb_valid = 1'b1;
    wb_exc   = 6'b010000;
    settle();
    check("ale_wb_ex", 32'(wb_ex), 32'd1);
    check("ale_ecode", 32'(wb_ecode), 32'h09);
    check("ale_badv_we", 32'(wb_badv_we), 32'd1);
    check("ale_badv", wb_badv, 32'h0000_0003);
    check("ale_kill", 32'(wb_kill), 32'd1);
    check("ale_flush_T", 32'(pipe_flush), 32'd1);
    check("ale_eret", 32'(eret_flush), 32'd0);
    tick();
    wb_idle();
    settle();
    check("ale_T1_wb_ex", 32'(wb_ex), 32'd0);
    check("ale_T1_flush", 32'(pipe_flush), 32'd1);
    check("ale_T1_rv", 32'(redirect_valid), 32'd0);
    tick();
    settle();
    check("ale_T2_rv", 32'(redirect_valid), 32'd0);
    tick();
    settle();
    check("ale_T3_rv", 32'(redirect_valid), 32'd1);
    check("ale_T3_pc", redirect_pc, 32'h1c00_8000);
    check("ale_T3_flush", 32'(pipe_flush), 32'd1);
    tick();
    settle();
    check("ale_T4_rv", 32'(redirect_valid), 32'd0);
    check("ale_T4_flush", 32'(pipe_flush), 32'd0);

    // ertn
    wb_valid = 1'b1;
    wb_ertn  = 1'b1;
    settle();
    check("ertn_eret", 32'(eret_flush), 32'd1);
    check("ertn_wb_ex", 32'(wb_ex), 32'd0);
    check("ertn_ecode", 32'(wb_ecode), 32'd0);
    tick();
    wb_idle();
    settle();
    check("ertn_T1_eret", 32'(eret_flush), 32'd0);
    tick();
    tick();
    settle();
    check("ertn_T3_rv", 32'(redirect_valid), 32'd1);
    check("ertn_T3_pc", redirect_pc, 32'h1c00_0200);
    tick();

    // Interrupt: sources visible to take only one cycle later
    csr_crmd_ie  = 1'b1;
    csr_estat_is = 13'h0800;
    csr_ecfg_lie = 13'h0800;
    wb_valid     = 1'b1;
    settle();
    check("int_latency_flush", 32'(pipe_flush), 32'd0);
    tick();
    wb_exc = 6'b000100;
    settle();
    check("int_wb_ex", 32'(wb_ex), 32'd1);
    check("int_ecode", 32'(wb_ecode), 32'h00);
    check("int_badv_we", 32'(wb_badv_we), 32'd0);
    tick();
    wb_idle();
    csr_crmd_ie = 1'b0;
    tick();
    tick();
    settle();
    check("int_T3_pc", redirect_pc, 32'h1c00_8000);
    tick();

    // Same SYS with interrupts globally disabled
    wb_valid = 1'b1;
    wb_exc   = 6'b000100;
    settle();
    check("sys_ecode", 32'(wb_ecode), 32'h0b);
    check("sys_wb_ex", 32'(wb_ex), 32'd1);
    tick();
    wb_idle();
    csr_estat_is = 13'd0;
    csr_ecfg_lie = 13'd0;
    tick();
    tick();
    tick();

    // Back-pressure on the redirect
    redirect_ready = 1'b0;
    csr_eentry     = 32'h1c00_9000;
    wb_valid       = 1'b1;
    wb_exc         = 6'b001000;
    settle();
    check("brk_ecode", 32'(wb_ecode), 32'h0c);
    tick();
    wb_idle();
    csr_eentry = 32'h1c00_a000;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      wb_valid = i[0];
      wb_exc   = 6'b000100;
      settle();
      check("bp_rv", 32'(redirect_valid), 32'd1);
      check("bp_pc", redirect_pc, 32'h1c00_9000);
      check("bp_kill", 32'(wb_kill), 32'(i[0]));
      check("bp_wb_ex", 32'(wb_ex), 32'd0);
    end
    tick();
    wb_idle();
    redirect_ready = 1'b1;
    settle();
    check("bp_hs_rv", 32'(redirect_valid), 32'd1);
    check("bp_hs_flush", 32'(pipe_flush), 32'd1);
    tick();
    settle();
    check("bp_done_rv", 32'(redirect_valid), 32'd0);
    check("bp_done_flush", 32'(pipe_flush), 32'd0);

    // ADEF + INE + ertn
    wb_valid = 1'b1;
    wb_exc   = 6'b000011;
    wb_ertn  = 1'b1;
    wb_pc    = 32'h1c00_0300;
    settle();
    check("adef_ecode", 32'(wb_ecode), 32'h08);
    check("adef_sub", 32'(wb_esubcode), 32'd0);
    check("adef_badv", wb_badv, 32'h1c00_0300);
    check("adef_eret", 32'(eret_flush), 32'd0);
    tick();
    wb_idle();
    tick();
    tick();
    settle();
    check("adef_pc", redirect_pc, 32'h1c00_a000);
    tick();

    // ADEM
    wb_valid = 1'b1;
    wb_exc   = 6'b100000;
    wb_vaddr = 32'h8000_0010;
    settle();
    check("adem_ecode", 32'(wb_ecode), 32'h08);
    check("adem_sub", 32'(wb_esubcode), 32'd1);
    check("adem_badv", wb_badv, 32'h8000_0010);
    tick();
    wb_idle();

    // Reset while in FLUSH
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("rmid_flush", 32'(pipe_flush), 32'd0);
    check("rmid_rv", 32'(redirect_valid), 32'd0);
    check("rmid_pc", redirect_pc, 32'd0);
    check("rmid_kill", 32'(wb_kill), 32'd0);
    tick();
    tick();
    settle();
    check("rmid_late_rv", 32'(redirect_valid), 32'd0);
    wb_valid = 1'b1;
    wb_exc   = 6'b010000;
    wb_vaddr = 32'h0000_0007;
    settle();
    check("rmid_ale_badv", wb_badv, 32'h0000_0007);
    tick();
    wb_idle();
    tick();
    tick();
    settle();
    check("rmid_ale_rv", 32'(redirect_valid), 32'd1);
    check("rmid_ale_pc", redirect_pc, 32'h1c00_a000);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
